// File: rtl/doorlock_ctrl_param.sv
// Door-lock controller FSM: password set/confirm, lock, challenge, keypad
// shuffle, unlock, timed lockout after repeated wrong attempts and
// auto-relock. All strobes to the password memory and entry buffer are
// registered single-cycle pulses.
module doorlock_ctrl_param #(
  parameter int SEED_W             = 32,
  parameter int ERR_W              = 4,
  parameter int MAX_ERRORS         = 5,
  parameter int LONG_PRESS_CYCLES  = 10,
  parameter int SHUFFLE_CYCLES     = 10,
  parameter int LOCKOUT_CYCLES     = 50,
  parameter int AUTO_RELOCK_CYCLES = 100,
  parameter int TMR_W              = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              confirm_i,
  input  logic              shuffle_i,
  input  logic              input_valid_i,
  input  logic              same_i,
  input  logic              master_same_i,
  input  logic              mem_limit_i,
  input  logic              buff_limit_i,
  output logic [SEED_W-1:0] seed_o,
  output logic              shuffle_init_o,
  output logic              mem_rst_o,
  output logic              mem_sl_o,
  output logic              buff_rst_o,
  output logic              buff_sl_o,
  output logic [2:0]        state_o,
  output logic [ERR_W-1:0]  error_cnt_o,
  output logic              unlocked_o,
  output logic              locked_out_o
);

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_SET_PSW     = 3'd1,
    ST_CONFIRM_PSW = 3'd2,
    ST_CHALLENGE   = 3'd3,
    ST_SHUFFLE     = 3'd4,
    ST_LOCKED      = 3'd5,
    ST_UNLOCKED    = 3'd6,
    ST_LOCKOUT     = 3'd7
  } state_t;

  // Timer thresholds are "last cycle" values: the state is left while the
  // timer shows N-1, so the state is occupied for exactly N cycles.
  localparam logic [TMR_W-1:0] SHUF_LAST  = TMR_W'(SHUFFLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RELOCK_LAST = TMR_W'(AUTO_RELOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] LONG_HOLD  = TMR_W'(LONG_PRESS_CYCLES);
  localparam logic [ERR_W:0]   MAX_ERR    = (ERR_W+1)'(MAX_ERRORS);

  state_t             state, state_nx;
  state_t             origin, origin_nx;
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   hold;
  logic [SEED_W-1:0]  seed;
  logic               conf_prev, shuf_prev;
  logic               conf_rel, shuf_rel, long_press;
  logic [ERR_W-1:0]   error_cnt, err_nx;
  logic [ERR_W:0]     err_inc;
  logic               wrong;
  logic               shuffle_init_nx, mem_rst_nx, mem_sl_nx, buff_rst_nx, buff_sl_nx;

  assign conf_rel   = conf_prev & ~confirm_i;
  assign shuf_rel   = shuf_prev & ~shuffle_i;
  assign long_press = (hold >= LONG_HOLD);
  assign err_inc    = {1'b0, error_cnt} + (ERR_W+1)'(1);

  assign seed_o       = seed;
  assign state_o      = state;
  assign error_cnt_o  = error_cnt;
  assign unlocked_o   = (state == ST_UNLOCKED);
  assign locked_out_o = (state == ST_LOCKOUT);

  // Next-state, error count and strobe decisions for the current cycle.
  always_comb begin
    state_nx        = state;
    origin_nx       = origin;
    err_nx          = error_cnt;
    wrong           = 1'b0;
    shuffle_init_nx = 1'b0;
    mem_rst_nx      = 1'b0;
    mem_sl_nx       = 1'b0;
    buff_rst_nx     = 1'b0;
    buff_sl_nx      = 1'b0;
    case (state)
      ST_INIT: begin
        state_nx   = ST_SET_PSW;
        mem_rst_nx = 1'b1;
      end
      ST_SET_PSW: begin
        if (shuf_rel) begin
          origin_nx       = state;
          state_nx        = ST_SHUFFLE;
          shuffle_init_nx = 1'b1;
        end else if (conf_rel) begin
          state_nx    = ST_CONFIRM_PSW;
          buff_rst_nx = 1'b1;
        end else if (input_valid_i) begin
          if (mem_limit_i) mem_rst_nx = 1'b1;
          else             mem_sl_nx  = 1'b1;
        end
      end
      ST_CONFIRM_PSW: begin
        if (shuf_rel) begin
          origin_nx       = state;
          state_nx        = ST_SHUFFLE;
          shuffle_init_nx = 1'b1;
        end else if (conf_rel) begin
          if (same_i) begin
            state_nx = ST_LOCKED;
          end else begin
            state_nx   = ST_SET_PSW;
            mem_rst_nx = 1'b1;
          end
        end else if (input_valid_i) begin
          if (buff_limit_i) begin
            state_nx   = ST_SET_PSW;
            mem_rst_nx = 1'b1;
          end else begin
            buff_sl_nx = 1'b1;
          end
        end
      end
      ST_CHALLENGE: begin
        if (shuf_rel) begin
          origin_nx       = state;
          state_nx        = ST_SHUFFLE;
          shuffle_init_nx = 1'b1;
        end else if (conf_rel) begin
          if (master_same_i || same_i) begin
            state_nx = ST_UNLOCKED;
            err_nx   = '0;
          end else begin
            wrong = 1'b1;
          end
        end else if (input_valid_i) begin
          if (buff_limit_i) wrong      = 1'b1;
          else              buff_sl_nx = 1'b1;
        end
      end
      ST_SHUFFLE: begin
        if (timer == SHUF_LAST) state_nx = origin;
      end
      ST_LOCKED: begin
        if (conf_rel) begin
          state_nx    = ST_CHALLENGE;
          buff_rst_nx = 1'b1;
        end
      end
      ST_UNLOCKED: begin
        if (conf_rel) begin
          if (long_press) begin
            state_nx   = ST_SET_PSW;
            mem_rst_nx = 1'b1;
          end else begin
            state_nx = ST_LOCKED;
          end
        end else if ((AUTO_RELOCK_CYCLES != 0) && (timer == RELOCK_LAST)) begin
          state_nx = ST_LOCKED;
        end
      end
      ST_LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_nx = ST_LOCKED;
          err_nx   = '0;
        end
      end
      default: state_nx = ST_INIT;
    endcase
    if (wrong) begin
      if (err_inc < MAX_ERR) begin
        err_nx   = err_inc[ERR_W-1:0];
        state_nx = ST_LOCKED;
      end else begin
        err_nx   = MAX_ERR[ERR_W-1:0];
        state_nx = ST_LOCKOUT;
      end
    end
  end

  // State, saved shuffle origin, error count and registered strobes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= ST_INIT;
      origin         <= ST_INIT;
      error_cnt      <= '0;
      shuffle_init_o <= 1'b0;
      mem_rst_o      <= 1'b0;
      mem_sl_o       <= 1'b0;
      buff_rst_o     <= 1'b0;
      buff_sl_o      <= 1'b0;
    end else begin
      state          <= state_nx;
      origin         <= origin_nx;
      error_cnt      <= err_nx;
      shuffle_init_o <= shuffle_init_nx;
      mem_rst_o      <= mem_rst_nx;
      mem_sl_o       <= mem_sl_nx;
      buff_rst_o     <= buff_rst_nx;
      buff_sl_o      <= buff_sl_nx;
    end
  end

  // Shared state timer: restarts on any state change and on confirm activity in UNLOCKED.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      timer <= '0;
    end else if (state_nx != state) begin
      timer <= '0;
    end else if ((state == ST_UNLOCKED) && confirm_i) begin
      timer <= '0;
    end else if (timer != '1) begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Button history for release detection and saturating confirm hold length.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      conf_prev <= 1'b0;
      shuf_prev <= 1'b0;
      hold      <= '0;
    end else begin
      conf_prev <= confirm_i;
      shuf_prev <= shuffle_i;
      if (!confirm_i)      hold <= '0;
      else if (hold != '1) hold <= hold + TMR_W'(1);
    end
  end

  // Free-running seed counter for the keypad shuffler.
  always_ff @(posedge clk_i) begin
    if (reset_i) seed <= '0;
    else         seed <= seed + SEED_W'(1);
  end

endmodule
